sdp_x_x_cfg_triosy_collector: RTL and testbench
===============================================

SDP_X_X_CFG_TRIOSY_COLLECTOR -- requirements
Module: sdp_x_x_cfg_triosy_collector

Interface
REQ-001 Parameter NUM_RSC, default 4: number of triosy resources monitored, legal range 1..8.
REQ-002 Parameter TIMEOUT, default 16'd4096: maximum COLLECT cycles before a timeout is flagged, legal range 1..65535.
REQ-003 nvdla_core_clk  in  1  single clock; all state updates on its rising edge.
REQ-004 nvdla_core_rstn  in  1  reset, asynchronous assert, active-low.
REQ-005 layer_start  in  1  one-cycle pulse from register file: the layer config is latched and the core may consume it.
REQ-006 rsc_triosy_lz  in  NUM_RSC  per-resource triosy pulses from the core; bit 0 = cfg_mul_op, bit 1 = cfg_alu_op, bit 2 = cfg_mul_shift, bit 3 = cfg_precision.
REQ-007 cfg_done_rdy  in  1  register-file ready for the config-release handshake.
REQ-008 err_clr  in  1  one-cycle pulse that clears the sticky error flags.
REQ-009 cfg_done_vld  out  1  all resources consumed; config may be released.
REQ-010 cfg_busy  out  1  high while the state is COLLECT or DONE.
REQ-011 rsc_seen  out  NUM_RSC  sticky per-resource consumed flags for the current layer.
REQ-012 layer_cnt  out  8  count of completed release handshakes.
REQ-013 err_stray  out  1  sticky: triosy pulse or layer_start arrived outside its legal state.
REQ-014 err_timeout  out  1  sticky: COLLECT exceeded TIMEOUT cycles.

Function
REQ-015 The FSM SHALL have three states: IDLE, COLLECT and DONE; there is no other state.
REQ-016 IDLE SHALL go to COLLECT on layer_start; in the same cycle rsc_seen loads the rsc_triosy_lz bits present, so a pulse coincident with start counts.
REQ-017 In COLLECT, every cycle rsc_seen SHALL update to rsc_seen OR rsc_triosy_lz; a repeated pulse on an already-seen bit is harmless and raises no error.
REQ-018 COLLECT SHALL go to DONE in the cycle after the next value of rsc_seen becomes all-ones; the latency from the last triosy pulse to cfg_done_vld is exactly 1 cycle.
REQ-019 cfg_done_vld SHALL be high exactly while the state is DONE, and stays high until cfg_done_rdy is sampled high.
REQ-020 The handshake SHALL complete in the cycle where cfg_done_vld and cfg_done_rdy are both high; that cycle returns the FSM to IDLE, clears rsc_seen, and increments layer_cnt modulo 256 (255 wraps to 0).
REQ-021 A 16-bit timeout counter SHALL clear on entry to COLLECT and increment each COLLECT cycle.
REQ-022 When the timeout counter reaches TIMEOUT, err_timeout SHALL set; the FSM stays in COLLECT, and the counter saturates.
REQ-023 err_stray SHALL set on any rsc_triosy_lz bit while in IDLE or DONE.
REQ-024 err_stray SHALL also set on layer_start while in COLLECT or DONE; such a layer_start is otherwise ignored.
REQ-025 err_clr SHALL clear both error flags; if err_clr and a new error event occur in the same cycle, the flag SHALL end set.
REQ-026 Error flags SHALL NOT alter FSM transitions.
REQ-027 All outputs SHALL be driven directly from registers, with no combinational input-to-output path.

Reset
REQ-028 While nvdla_core_rstn is low, the FSM SHALL be IDLE and cfg_done_vld, cfg_busy, rsc_seen, layer_cnt, err_stray, err_timeout and the timeout counter SHALL all be 0.
REQ-029 Reset asserted mid-COLLECT or mid-DONE SHALL abandon the layer; there is no pending handshake after release.
REQ-030 The first layer_start SHALL be accepted on the first rising edge after nvdla_core_rstn deasserts.

Verification
REQ-031 Reset release, layer_start at cycle 0, then lz bits 0, 1, 2, 3 at cycles 2, 3, 4, 5, with cfg_done_rdy held high -> cfg_done_vld high in cycle 6 only; layer_cnt = 1 in cycle 7; err flags 0.
REQ-032 layer_start together with lz = 4'b1111 in the same cycle, cfg_done_rdy low for 3 cycles -> state DONE, cfg_done_vld held high for 3 cycles, completes on the 4th cycle, then IDLE.
REQ-033 lz bit 2 pulsed while IDLE -> err_stray = 1 and state unchanged; err_clr -> err_stray = 0.
REQ-034 TIMEOUT = 8, layer_start, only lz bits 0 and 1 pulsed -> err_timeout = 1 after 8 COLLECT cycles; later bits 2 and 3 pulsed -> DONE is still reached.
REQ-035 Nvdla_core_rstn driven low during DONE with cfg_done_vld high -> cfg_done_vld = 0 immediately (asynchronous) and layer_cnt = 0.
REQ-036 256 back-to-back layers -> layer_cnt wraps to 0; a second layer_start during COLLECT -> err_stray = 1 and rsc_seen is not cleared.

Source files
------------

// File: rtl/sdp_x_x_cfg_triosy_collector_if.sv
// Handshake and status bundle between the register file and the triosy collector.
// master = register-file side, slave = collector.
interface sdp_x_x_cfg_triosy_collector_if #(
    parameter int unsigned NUM_RSC = 4
);
    logic               layer_start;
    logic [NUM_RSC-1:0] rsc_triosy_lz;
    logic               cfg_done_rdy;
    logic               err_clr;
    logic               cfg_done_vld;
    logic               cfg_busy;
    logic [NUM_RSC-1:0] rsc_seen;
    logic [7:0]         layer_cnt;
    logic               err_stray;
    logic               err_timeout;

    modport master (
        output layer_start, rsc_triosy_lz, cfg_done_rdy, err_clr,
        input  cfg_done_vld, cfg_busy, rsc_seen, layer_cnt, err_stray, err_timeout
    );

    modport slave (
        input  layer_start, rsc_triosy_lz, cfg_done_rdy, err_clr,
        output cfg_done_vld, cfg_busy, rsc_seen, layer_cnt, err_stray, err_timeout
    );
endinterface

// File: rtl/sdp_x_x_cfg_triosy_collector.sv
// Collects per-resource triosy pulses for a layer config and releases the config
// through a vld/rdy handshake once every resource has consumed it.
module sdp_x_x_cfg_triosy_collector #(
    parameter int unsigned NUM_RSC = 4,
    parameter int unsigned TIMEOUT = 16'd4096
) (
    input  logic                           nvdla_core_clk,
    input  logic                           nvdla_core_rstn,
    sdp_x_x_cfg_triosy_collector_if.slave  cfg
);
    localparam int unsigned TMO_W   = 16;
    localparam int unsigned CNT_W   = 8;
    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t             state_q, state_nxt;
    logic [NUM_RSC-1:0] seen_q, seen_nxt;
    logic [CNT_W-1:0]   layer_cnt_q, layer_cnt_nxt;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_nxt;
    logic               stray_q, stray_nxt;
    logic               tmo_err_q, tmo_err_nxt;
    logic               vld_q, busy_q;
    logic               stray_ev, tmo_ev;
    logic [NUM_RSC-1:0] seen_or;

    // State and status registers; vld/busy are precomputed from the next state
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q     <= IDLE;
            seen_q      <= '0;
            layer_cnt_q <= '0;
            tmo_cnt_q   <= '0;
            stray_q     <= 1'b0;
            tmo_err_q   <= 1'b0;
            vld_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            seen_q      <= seen_nxt;
            layer_cnt_q <= layer_cnt_nxt;
            tmo_cnt_q   <= tmo_cnt_nxt;
            stray_q     <= stray_nxt;
            tmo_err_q   <= tmo_err_nxt;
            vld_q       <= (state_nxt == DONE);
            busy_q      <= (state_nxt != IDLE);
        end
    end

    // Next-state, seen-mask, counters and error events
    always_comb begin
        state_nxt     = state_q;
        seen_nxt      = seen_q;
        layer_cnt_nxt = layer_cnt_q;
        tmo_cnt_nxt   = tmo_cnt_q;
        stray_ev      = 1'b0;
        tmo_ev        = 1'b0;
        seen_or       = seen_q | cfg.rsc_triosy_lz;

        case (state_q)
            IDLE: begin
                if (cfg.layer_start) begin
                    state_nxt   = COLLECT;
                    seen_nxt    = cfg.rsc_triosy_lz;
                    tmo_cnt_nxt = '0;
                end else if (|cfg.rsc_triosy_lz) begin
                    stray_ev = 1'b1;
                end
            end
            COLLECT: begin
                seen_nxt = seen_or;
                stray_ev = cfg.layer_start;
                if (tmo_cnt_q != TMO_LIM) begin
                    tmo_cnt_nxt = tmo_cnt_q + TMO_W'(1);
                    tmo_ev      = (tmo_cnt_nxt == TMO_LIM);
                end
                if (&seen_or) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                stray_ev = cfg.layer_start | (|cfg.rsc_triosy_lz);
                if (cfg.cfg_done_rdy) begin
                    state_nxt     = IDLE;
                    seen_nxt      = '0;
                    layer_cnt_nxt = layer_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                seen_nxt  = '0;
            end
        endcase

        // A new event in the clearing cycle wins over err_clr
        stray_nxt   = (stray_q   & ~cfg.err_clr) | stray_ev;
        tmo_err_nxt = (tmo_err_q & ~cfg.err_clr) | tmo_ev;
    end

    assign cfg.cfg_done_vld = vld_q;
    assign cfg.cfg_busy     = busy_q;
    assign cfg.rsc_seen     = seen_q;
    assign cfg.layer_cnt    = layer_cnt_q;
    assign cfg.err_stray    = stray_q;
    assign cfg.err_timeout  = tmo_err_q;

endmodule

// File: tb/tb_sdp_x_x_cfg_triosy_collector.sv
// Randomized and directed bench for the triosy collector; dut_a (default timeout)
// is checked against a behavioural layer model, dut_b (TIMEOUT=8) for timeout.
module tb_sdp_x_x_cfg_triosy_collector;
    logic nvdla_core_clk = 1'b0;
    logic nvdla_core_rstn = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;

    sdp_x_x_cfg_triosy_collector_if #(.NUM_RSC(4)) if_a ();
    sdp_x_x_cfg_triosy_collector_if #(.NUM_RSC(4)) if_b ();

    sdp_x_x_cfg_triosy_collector #(.NUM_RSC(4)) dut_a (
        .nvdla_core_clk (nvdla_core_clk),
        .nvdla_core_rstn(nvdla_core_rstn),
        .cfg            (if_a)
    );

    sdp_x_x_cfg_triosy_collector #(.NUM_RSC(4), .TIMEOUT(8)) dut_b (
        .nvdla_core_clk (nvdla_core_clk),
        .nvdla_core_rstn(nvdla_core_rstn),
        .cfg            (if_b)
    );

    always #5 nvdla_core_clk = ~nvdla_core_clk;

    // Behavioural model of one layer's lifetime for dut_a
    bit         m_active, m_done, m_stray, m_tmo;
    logic [3:0] m_seen;
    int         m_cnt, m_coll;
    localparam int TIMEOUT_A = 4096;

    wire [15:0] obs_a = {if_a.cfg_done_vld, if_a.cfg_busy, if_a.rsc_seen, if_a.layer_cnt,
                         if_a.err_stray, if_a.err_timeout};
    wire [15:0] exp_a = {m_done, m_active, m_seen, 8'(m_cnt), m_stray, m_tmo};

    task automatic model_reset();
        m_active = 0; m_done = 0; m_stray = 0; m_tmo = 0;
        m_seen = '0; m_cnt = 0; m_coll = 0;
    endtask

    task automatic model_step(input bit st, input logic [3:0] lz, input bit rdy, input bit clr);
        bit ev_s = 0;
        bit ev_t = 0;
        if (!m_active) begin
            if (st) begin
                m_active = 1; m_seen = lz; m_coll = 0;
            end else if (lz != 0) ev_s = 1;
        end else if (!m_done) begin
            if (st) ev_s = 1;
            m_coll++;
            if (m_coll == TIMEOUT_A) ev_t = 1;
            m_seen = m_seen | lz;
            if (m_seen == 4'hF) m_done = 1;
        end else begin
            if (st || lz != 0) ev_s = 1;
            if (rdy) begin
                m_active = 0; m_done = 0; m_seen = '0; m_cnt = (m_cnt + 1) % 256;
            end
        end
        m_stray = (m_stray && !clr) || ev_s;
        m_tmo   = (m_tmo && !clr) || ev_t;
    endtask

    // Drive one clock of inputs to both DUTs (called at a negedge, returns at the next)
    task automatic cycle(input bit st, input logic [3:0] lz, input bit rdy, input bit clr);
        if_a.layer_start = st; if_a.rsc_triosy_lz = lz; if_a.cfg_done_rdy = rdy; if_a.err_clr = clr;
        if_b.layer_start = st; if_b.rsc_triosy_lz = lz; if_b.cfg_done_rdy = rdy; if_b.err_clr = clr;
        @(posedge nvdla_core_clk);
        model_step(st, lz, rdy, clr);
        @(negedge nvdla_core_clk);
    endtask

    task automatic test_reset();
        cycle(0, 4'h0, 0, 0);
        cycle(0, 4'h0, 0, 0);
        model_reset();
        n_chk++;
        if (obs_a !== 16'h0) $display("FAIL reset_a: got %h want %h", obs_a, 16'h0);
        else n_pass++;
        n_chk++;
        if ({if_b.cfg_done_vld, if_b.cfg_busy, if_b.layer_cnt, if_b.err_timeout} !== 11'h0)
            $display("FAIL reset_b: got vld=%b busy=%b cnt=%h tmo=%b", if_b.cfg_done_vld,
                     if_b.cfg_busy, if_b.layer_cnt, if_b.err_timeout);
        else n_pass++;
        nvdla_core_rstn = 1'b1;
    endtask

    // Start on the first edge after reset, one resource per cycle from cycle 2
    task automatic test_basic();
        for (int k = 0; k < 8; k++) begin
            logic [3:0] lz = (k >= 2 && k <= 5) ? 4'(1 << (k - 2)) : 4'h0;
            cycle(k == 0, lz, 1, 0);
            n_chk++;
            if (obs_a !== exp_a) $display("FAIL basic_k%0d: got %h want %h", k, obs_a, exp_a);
            else n_pass++;
            n_chk++;
            if (if_a.cfg_done_vld !== (k == 5)) $display("FAIL basic_vld_k%0d: got %b want %b", k, if_a.cfg_done_vld, k == 5);
            else n_pass++;
        end
        n_chk++;
        if (if_a.layer_cnt !== 8'd1 || if_a.err_stray !== 1'b0 || if_a.err_timeout !== 1'b0)
            $display("FAIL basic_end: got cnt=%0d stray=%b tmo=%b want 1 0 0", if_a.layer_cnt, if_a.err_stray, if_a.err_timeout);
        else n_pass++;
    endtask

    // All resources consumed with the start pulse; release held off for 3 cycles
    task automatic test_coincident();
        cycle(1, 4'hF, 0, 0);
        cycle(0, 4'h0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (obs_a !== exp_a || if_a.cfg_done_vld !== 1'b1)
                $display("FAIL coincident_hold%0d: got %h want %h", k, obs_a, exp_a);
            else n_pass++;
            cycle(0, 4'h0, (k == 2), 0);
        end
        n_chk++;
        if (obs_a !== exp_a || if_a.cfg_busy !== 1'b0 || if_a.layer_cnt !== 8'd2)
            $display("FAIL coincident_release: got %h want %h", obs_a, exp_a);
        else n_pass++;
    endtask

    task automatic test_stray();
        cycle(0, 4'h4, 0, 0);
        n_chk++;
        if (obs_a !== exp_a || if_a.err_stray !== 1'b1 || if_a.cfg_busy !== 1'b0)
            $display("FAIL stray_idle: got %h want %h", obs_a, exp_a);
        else n_pass++;
        cycle(0, 4'h1, 0, 1);
        n_chk++;
        if (obs_a !== exp_a || if_a.err_stray !== 1'b1)
            $display("FAIL stray_clr_and_event: got %h want %h", obs_a, exp_a);
        else n_pass++;
        cycle(0, 4'h0, 0, 1);
        n_chk++;
        if (obs_a !== exp_a || if_a.err_stray !== 1'b0)
            $display("FAIL stray_clr: got %h want %h", obs_a, exp_a);
        else n_pass++;
    endtask

    task automatic test_timeout();
        cycle(1, 4'h1, 0, 0);
        for (int j = 1; j <= 8; j++) begin
            cycle(0, (j == 1) ? 4'h2 : 4'h0, 0, 0);
            n_chk++;
            if (if_b.err_timeout !== (j == 8) || if_b.cfg_busy !== 1'b1)
                $display("FAIL timeout_c%0d: got tmo=%b busy=%b want tmo=%b busy=1", j, if_b.err_timeout, if_b.cfg_busy, j == 8);
            else n_pass++;
        end
        cycle(0, 4'h4, 0, 0);
        cycle(0, 4'h8, 0, 0);
        n_chk++;
        if (if_b.cfg_done_vld !== 1'b1 || if_b.err_timeout !== 1'b1 || obs_a !== exp_a)
            $display("FAIL timeout_done: got vld=%b tmo=%b a=%h want 1 1 a=%h", if_b.cfg_done_vld, if_b.err_timeout, obs_a, exp_a);
        else n_pass++;
        cycle(0, 4'h0, 1, 1);
        n_chk++;
        if (if_b.cfg_busy !== 1'b0 || if_b.err_timeout !== 1'b0 || obs_a !== exp_a)
            $display("FAIL timeout_release: got busy=%b tmo=%b want 0 0", if_b.cfg_busy, if_b.err_timeout);
        else n_pass++;
    endtask

    // Reset landing mid-cycle while waiting in DONE
    task automatic test_reset_mid();
        cycle(1, 4'h3, 0, 0);
        cycle(0, 4'hC, 0, 0);
        n_chk++;
        if (if_a.cfg_done_vld !== 1'b1 || if_a.layer_cnt === 8'd0)
            $display("FAIL reset_mid_pre: got vld=%b cnt=%0d want vld=1 cnt!=0", if_a.cfg_done_vld, if_a.layer_cnt);
        else n_pass++;
        #2 nvdla_core_rstn = 1'b0;
        #1;
        model_reset();
        n_chk++;
        if (obs_a !== 16'h0) $display("FAIL reset_mid_async: got %h want %h", obs_a, 16'h0);
        else n_pass++;
        @(negedge nvdla_core_clk);
        nvdla_core_rstn = 1'b1;
        cycle(0, 4'h0, 1, 0);
        n_chk++;
        if (obs_a !== exp_a || if_a.cfg_done_vld !== 1'b0 || if_a.layer_cnt !== 8'd0)
            $display("FAIL reset_mid_after: got %h want %h", obs_a, exp_a);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        for (int l = 0; l < 256; l++) begin
            cycle(1, 4'hF, 1, 0);
            cycle(0, 4'h0, 1, 0);
            cycle(0, 4'h0, 1, 0);
            if (obs_a !== exp_a) bad++;
        end
        n_chk++;
        if (bad != 0 || if_a.layer_cnt !== 8'd0)
            $display("FAIL b2b_wrap: got cnt=%0d bad_layers=%0d want cnt=0 bad=0", if_a.layer_cnt, bad);
        else n_pass++;
        cycle(1, 4'h1, 0, 0);
        cycle(1, 4'h2, 0, 0);
        n_chk++;
        if (obs_a !== exp_a || if_a.err_stray !== 1'b1 || if_a.rsc_seen !== 4'h3)
            $display("FAIL b2b_restart: got %h want %h", obs_a, exp_a);
        else n_pass++;
        cycle(0, 4'hC, 0, 1);
        cycle(0, 4'h0, 1, 0);
        n_chk++;
        if (obs_a !== exp_a || if_a.layer_cnt !== 8'd1)
            $display("FAIL b2b_finish: got %h want %h", obs_a, exp_a);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bit         st  = ($urandom_range(0, 7) == 0);
            logic [3:0] lz  = 4'($urandom) & 4'($urandom) & 4'($urandom);
            bit         rdy = ($urandom_range(0, 2) != 0);
            bit         clr = ($urandom_range(0, 15) == 0);
            cycle(st, lz, rdy, clr);
            n_chk++;
            if (obs_a !== exp_a) $display("FAIL random_i%0d: got %h want %h", i, obs_a, exp_a);
            else n_pass++;
        end
    endtask

    initial begin
        if_a.layer_start = 0; if_a.rsc_triosy_lz = '0; if_a.cfg_done_rdy = 0; if_a.err_clr = 0;
        if_b.layer_start = 0; if_b.rsc_triosy_lz = '0; if_b.cfg_done_rdy = 0; if_b.err_clr = 0;
        model_reset();
        @(negedge nvdla_core_clk);
        test_reset();
        test_basic();
        test_coincident();
        test_stray();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
